// File: rtl/demux12_stream.sv
// Registered 1-to-2 stream demultiplexer with valid/ready on every channel.
// Each destination owns a one-entry output slot and a wrapping transfer counter.
module demux12_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_sel,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

    logic can_load_a, can_load_b;
    logic load_a, load_b;
    logic drain_a, drain_b;

    // A slot may load when empty or when its current beat leaves this edge.
    assign can_load_a = !a_valid_q || a_ready;
    assign can_load_b = !b_valid_q || b_ready;

    assign s_ready = s_sel ? can_load_b : can_load_a;

    assign load_a  = s_valid && !s_sel && can_load_a;
    assign load_b  = s_valid &&  s_sel && can_load_b;
    assign drain_a = a_valid_q && a_ready;
    assign drain_b = b_valid_q && b_ready;

    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        if (load_a) begin
            a_valid_d = 1'b1;
            a_data_d  = s_data;
        end else if (drain_a) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        if (load_b) begin
            b_valid_d = 1'b1;
            b_data_d  = s_data;
        end else if (drain_b) begin
            b_valid_d = 1'b0;
        end
    end

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (drain_a) begin
            a_cnt_d = a_cnt_q + 1'b1;
        end
        if (drain_b) begin
            b_cnt_d = b_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_cnt_q   <= a_cnt_d;
            b_cnt_q   <= b_cnt_d;
        end
    end

    assign a_data  = a_data_q;
    assign a_valid = a_valid_q;
    assign b_data  = b_data_q;
    assign b_valid = b_valid_q;
    assign a_count = a_cnt_q;
    assign b_count = b_cnt_q;

endmodule

// File: tb/tb_demux12_stream.sv
// Bench for demux12_stream: directed table, hand sequences, random traffic
// checked against a queue-based model of the two destination slots.
module tb_demux12_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_sel;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] a_count;
    logic [7:0] b_count;

    demux12_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_sel(s_sel),
        .s_valid(s_valid), .s_ready(s_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: each destination is a queue holding at most one beat.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] la, lb;
    int         ca, cb;

    typedef struct {
        logic       sel;
        logic       v;
        logic [7:0] d;
        logic       ar;
        logic       br;
        logic [34:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [34:0] mk(
        logic sr, logic av, logic [7:0] ad,
        logic bv, logic [7:0] bd, logic [7:0] ac, logic [7:0] bc);
        return {sr, av, ad, bv, bd, ac, bc};
    endfunction

    function automatic logic [34:0] got();
        return {s_ready, a_valid, a_data, b_valid, b_data, a_count, b_count};
    endfunction

    task automatic chk(input string nm, input logic [34:0] g,
                       input logic [34:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, g, e);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        la = 8'h00;
        lb = 8'h00;
        ca = 0;
        cb = 0;
    endtask

    // One clock cycle: drive, check at negedge, advance model, cross edge.
    task automatic cycle(input logic sel, input logic v, input logic [7:0] d,
                         input logic ar, input logic br,
                         input bit use_tbl, input logic [34:0] texp,
                         input string nm, output logic acc);
        logic sr;
        s_sel   = sel;
        s_valid = v;
        s_data  = d;
        a_ready = ar;
        b_ready = br;
        @(negedge clk);
        sr = sel ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
        if (use_tbl)
            chk(nm, got(), texp);
        else
            chk(nm, got(), mk(sr, qa.size() != 0, la, qb.size() != 0, lb,
                               8'(ca), 8'(cb)));
        if (qa.size() != 0 && ar) begin
            void'(qa.pop_front());
            ca = (ca + 1) % 256;
        end
        if (qb.size() != 0 && br) begin
            void'(qb.pop_front());
            cb = (cb + 1) % 256;
        end
        acc = v && sr;
        if (acc && !sel) begin
            qa.push_back(d);
            la = d;
        end
        if (acc && sel) begin
            qb.push_back(d);
            lb = d;
        end
        @(posedge clk);
        #1;
    endtask

    logic       acc;
    logic       p_v, p_sel;
    logic [7:0] p_d;
    int         c0;

    initial begin
        tbl[0]  = '{0, 0, 8'h00, 1, 1, mk(1, 0, 8'h00, 0, 8'h00, 0, 0)};
        tbl[1]  = '{1, 0, 8'h00, 1, 1, mk(1, 0, 8'h00, 0, 8'h00, 0, 0)};
        tbl[2]  = '{0, 1, 8'h11, 1, 1, mk(1, 0, 8'h00, 0, 8'h00, 0, 0)};
        tbl[3]  = '{1, 1, 8'h22, 1, 1, mk(1, 1, 8'h11, 0, 8'h00, 0, 0)};
        tbl[4]  = '{0, 0, 8'h00, 0, 1, mk(1, 0, 8'h11, 1, 8'h22, 1, 0)};
        tbl[5]  = '{0, 1, 8'h33, 0, 1, mk(1, 0, 8'h11, 0, 8'h22, 1, 1)};
        tbl[6]  = '{0, 1, 8'h44, 0, 1, mk(0, 1, 8'h33, 0, 8'h22, 1, 1)};
        tbl[7]  = '{0, 1, 8'h44, 0, 1, mk(0, 1, 8'h33, 0, 8'h22, 1, 1)};
        tbl[8]  = '{1, 1, 8'h55, 0, 1, mk(1, 1, 8'h33, 0, 8'h22, 1, 1)};
        tbl[9]  = '{0, 1, 8'h44, 1, 0, mk(1, 1, 8'h33, 1, 8'h55, 1, 1)};
        tbl[10] = '{1, 0, 8'h00, 1, 1, mk(1, 1, 8'h44, 1, 8'h55, 2, 1)};
        tbl[11] = '{0, 0, 8'h00, 1, 1, mk(1, 0, 8'h44, 0, 8'h55, 3, 2)};

        rst = 1'b1;
        s_data = 8'h00;
        s_sel = 1'b0;
        s_valid = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", got(), mk(1, 0, 8'h00, 0, 8'h00, 0, 0));
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 12; i++)
            cycle(tbl[i].sel, tbl[i].v, tbl[i].d, tbl[i].ar, tbl[i].br,
                  1'b1, tbl[i].exp, $sformatf("table_%0d", i), acc);

        c0 = cb;
        for (int i = 0; i < 10; i++)
            cycle(1, 1, 8'(8'h60 + i), 1, 1, 1'b0, '0, "stream_b", acc);
        cycle(0, 0, 8'h00, 1, 1, 1'b0, '0, "stream_idle", acc);
        chk("stream_b_count", {27'd0, b_count}, {27'd0, 8'(c0 + 10)});
        chk("stream_b_last", {27'd0, b_data}, {27'd0, 8'h69});

        c0 = ca;
        for (int i = 0; i < 257; i++)
            cycle(0, 1, 8'(i), 1, 1, 1'b0, '0, "wrap_a", acc);
        cycle(0, 0, 8'h00, 1, 1, 1'b0, '0, "wrap_idle", acc);
        chk("wrap_a_count", {27'd0, a_count}, {27'd0, 8'((c0 + 257) % 256)});

        p_v = 1'b0;
        p_sel = 1'b0;
        p_d = 8'h00;
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(p_v && !acc)) begin
                p_v   = ($urandom_range(0, 3) != 0);
                p_sel = 1'($urandom_range(0, 1));
                p_d   = 8'($urandom);
            end
            cycle(p_sel, p_v, p_d, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 2) != 0), 1'b0, '0, "random", acc);
        end

        cycle(0, 1, 8'hA1, 0, 0, 1'b0, '0, "fill_a", acc);
        cycle(1, 1, 8'hB2, 0, 0, 1'b0, '0, "fill_b", acc);
        s_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {16'd0, a_valid, b_valid, a_count, b_count},
            {16'd0, 1'b0, 1'b0, 8'h00, 8'h00});
        chk("async_reset_data", {19'd0, a_data, b_data}, 35'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(0, 1, 8'h5A, 1, 1, 1'b0, '0, "post_rst_a", acc);
        cycle(1, 1, 8'hC3, 1, 1, 1'b0, '0, "post_rst_b", acc);
        cycle(0, 0, 8'h00, 1, 1, 1'b0, '0, "post_rst_idle", acc);
        cycle(0, 0, 8'h00, 1, 1, 1'b0, '0, "post_rst_end", acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
